// File: rtl/rtc_pkg.sv
// Shared RTC definitions: field width, seconds limit, countdown state encoding
// and a saturating clamp used when loading MM:SS presets.
package rtc_pkg;

  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } cd_state_e;

  function automatic logic [FIELD_W-1:0] clamp_field(
    input logic [FIELD_W-1:0] value,
    input logic [FIELD_W-1:0] limit
  );
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Single-clock prescaler: counts 0..CLK_DIV-1 while enabled and flags the
// terminal-count cycle. Holds when disabled; clear restarts the period.
module rtc_tick_gen #(
  parameter int CLK_DIV = 125_000_000
) (
  input  logic clk_125MHz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == TERM);

  always_ff @(posedge clk_125MHz) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Preloadable MM:SS countdown timer: FSM, borrow down-counter and preset clamp,
// decremented once per prescaler period; all outputs come straight from flops.
module countdown_timer
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 125_000_000,
  parameter int MAX_MIN = 59
) (
  input  logic               clk_125MHz,
  input  logic               rst,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_min,
  input  logic [FIELD_W-1:0] load_sec,
  input  logic               start,
  input  logic               stop,
  output logic [FIELD_W-1:0] min_out,
  output logic [FIELD_W-1:0] sec_out,
  output logic               running,
  output logic               tick_1Hz,
  output logic               done,
  output logic               expired
);

  localparam logic [FIELD_W-1:0] MIN_LIM = FIELD_W'(MAX_MIN);

  cd_state_e          state, state_n;
  logic [FIELD_W-1:0] min_r, min_n;
  logic [FIELD_W-1:0] sec_r, sec_n;
  logic               tick_n, done_n;

  logic load_ok;
  logic nonzero;
  logic go_start;
  logic last_sec;
  logic pre_clear;
  logic pre_en;
  logic pre_tick;

  assign nonzero  = (min_r != '0) || (sec_r != '0);
  assign last_sec = (min_r == '0) && (sec_r == FIELD_W'(1));
  assign load_ok  = load && (state != ST_RUN);
  // load outranks start; stop outranks start; an empty preset never starts
  assign go_start = start && !stop && !load && nonzero &&
                    ((state == ST_IDLE) || (state == ST_PAUSE));

  // a resume from PAUSE keeps the partial second, so only IDLE entry clears
  assign pre_clear = load_ok || (go_start && (state == ST_IDLE));
  assign pre_en    = (state == ST_RUN) && !stop;

  rtc_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_125MHz (clk_125MHz),
    .rst        (rst),
    .clear      (pre_clear),
    .enable     (pre_en),
    .tick       (pre_tick)
  );

  always_comb begin
    state_n = state;
    min_n   = min_r;
    sec_n   = sec_r;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE, ST_PAUSE: begin
        if (load_ok) begin
          min_n   = clamp_field(load_min, MIN_LIM);
          sec_n   = clamp_field(load_sec, SEC_MAX);
          state_n = ST_IDLE;
        end else if (go_start) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_PAUSE;
        end else if (pre_tick) begin
          tick_n = 1'b1;
          if (sec_r != '0) begin
            sec_n = sec_r - FIELD_W'(1);
          end else begin
            sec_n = SEC_MAX;
            min_n = min_r - FIELD_W'(1);
          end
          if (last_sec) begin
            state_n = ST_EXPIRED;
            done_n  = 1'b1;
          end
        end
      end
      ST_EXPIRED: begin
        if (load_ok) begin
          min_n   = clamp_field(load_min, MIN_LIM);
          sec_n   = clamp_field(load_sec, SEC_MAX);
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_125MHz) begin
    if (rst) begin
      state    <= ST_IDLE;
      min_r    <= '0;
      sec_r    <= '0;
      tick_1Hz <= 1'b0;
      done     <= 1'b0;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_n;
      min_r    <= min_n;
      sec_r    <= sec_n;
      tick_1Hz <= tick_n;
      done     <= done_n;
      running  <= (state_n == ST_RUN);
      expired  <= (state_n == ST_EXPIRED);
    end
  end

  assign min_out = min_r;
  assign sec_out = sec_r;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Preloadable minutes:seconds countdown timer. It is the down-counting counterpart to the RTC's up-counting time counter. An operator loads an MM:SS value, starts it, and may pause or resume it. The block decrements once per second from a single-clock prescaler, with no derived clocks. When it reaches 00:00 it raises `done` and holds. It sits beside the time counter and feeds the same display path through `min_out`/`sec_out`.

## Interface
- `CLK_DIV`, 125_000_000: clock cycles per one-second tick. Must be at least 2.
- `MAX_MIN`, 59: largest loadable minute value.
- `clk_125MHz` in 1: sole clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: capture `load_min`/`load_sec` (single-cycle qualifier).
- `load_min` in 6: preset minutes.
- `load_sec` in 6: preset seconds.
- `start` in 1: begin or resume counting (level; sampled each cycle).
- `stop` in 1: pause counting (level; sampled each cycle).
- `min_out` out 6: current minutes. Reset value 0.
- `sec_out` out 6: current seconds. Reset value 0.
- `running` out 1: high in RUN. Reset value 0.
- `tick_1Hz` out 1: one-cycle pulse on every decrement. Reset value 0.
- `done` out 1: one-cycle pulse on reaching 00:00. Reset value 0.
- `expired` out 1: level, high in EXPIRED. Reset value 0.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset forces IDLE, counters 00:00, prescaler 0, and all flags 0.
- **Load.** `load` is accepted in IDLE, PAUSE, and EXPIRED and ignored in RUN.
  - Values are clamped: seconds above 59 become 59; minutes above `MAX_MIN` become `MAX_MIN`.
  - A load in PAUSE or EXPIRED moves to IDLE and clears the prescaler.
- **Start.** From IDLE or PAUSE, `start=1`, `stop=0`, and a value other than 00:00 moves to RUN.
  - Entry from IDLE clears the prescaler.
  - Entry from PAUSE keeps the prescaler value, so a partial second resumes.
  - `start` with 00:00 is ignored and the state stays put.
- **RUN.** The prescaler counts 0..CLK_DIV-1 and wraps. On the terminal count cycle:
  - `tick_1Hz` pulses.
  - If `sec_out` > 0, seconds decrement. Otherwise seconds become 59 and minutes decrement.
  - If the new value is 00:00, go to EXPIRED and pulse `done`.
- **Stop.** `stop=1` in RUN moves to PAUSE at the next edge. Counters and prescaler hold.
- **Simultaneous inputs.**
  - `stop` beats `start`.
  - `load` beats `start` in non-RUN states: the load takes effect and start is ignored that cycle.
  - `rst` beats everything.
- **EXPIRED.** Holds 00:00 with `expired=1`. `start` and `stop` are ignored. Only `load` or `rst` exits.
- **Reset mid-operation.** Reset aborts any state without emitting `done` or `tick_1Hz`.

## Timing
- All outputs are registered and change only on `clk_125MHz` rising edges.
- **Start to first decrement.** If `start` is sampled at edge N (from IDLE), `running` is high after N. The first decrement and `tick_1Hz` occur after edge N+CLK_DIV. Later decrements follow every CLK_DIV cycles.
- **Terminal decrement.** `done` and `tick_1Hz` are high in the same cycle that the outputs first show 00:00. `expired` rises in that same cycle, and `running` falls.
- **Pause/resume.** Stopping after k prescaler counts and then resuming makes the next decrement occur CLK_DIV-k cycles after resume.
- **Load latency.** Loaded values appear on the outputs one cycle after `load` is sampled.

## Structure
- Shared package `rtc_pkg`:
  - state enum (IDLE, RUN, PAUSE, EXPIRED)
  - `SEC_MAX = 59`
  - 6-bit field width constant (shared with the time counter and display path)
- Sub-module `rtc_tick_gen`: parameterised prescaler with `clear`, `enable` (hold when low), and `tick` outputs. Reusable by the time counter.
- The top level contains the FSM, the MM:SS down-counter with borrow, and the clamp logic.

## Test plan
All scenarios use CLK_DIV=4.
- **Basic run.** Reset, load 00:03, start. Expect `sec_out` 2, 1, 0 at 4-cycle intervals. `done` pulses once with the final value. `expired=1`, `running=0`.
- **Borrow.** Load 01:00, start. After 4 cycles expect 00:59 with `tick_1Hz` high for one cycle. Continue to 00:00 after 60 ticks total, then `done` pulses.
- **Pause mid-second.** Load 00:02, start, assert `stop` after 2 cycles, hold it 10 cycles, then release it and start. The next decrement is 2 cycles after resume. No decrement occurs while paused.
- **Clamp and ignored inputs.**
  - Load min=63, sec=63 gives 59:59.
  - `load` during RUN leaves the value unchanged.
  - `start` at 00:00 keeps IDLE.
  - `start` and `stop` asserted together from IDLE stay in IDLE.
- **Expired exit.** In EXPIRED, pulse `start`: no change. Load 00:05: state goes to IDLE and the outputs show 00:05 one cycle later.
- **Reset mid-run.** Assert `rst` one cycle before the terminal tick of 00:01. Expect no `done`, outputs 00:00, IDLE.
